// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in parallel-out deserializer.
package sipo_pkg;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // Bits needed to count 0..n-1 (minimum 1).
  function automatic int clog2(input int n);
    for (int r = 1; r < 32; r++) begin
      if ((1 << r) >= n) return r;
    end
    return 32;
  endfunction

endpackage

// File: rtl/sipo_deserializer_if.sv
// Serial input, parallel valid/ready output and status bundle of the deserializer.
interface sipo_deserializer_if #(
  parameter int WIDTH = 4
);
  logic             ser_in;
  logic             ser_valid;
  logic             sync_in;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             par_ready;
  logic             locked;
  logic             overflow;
  logic             sync_err;

  // Master drives the serial link and consumes words; slave is the deserializer.
  modport master (
    output ser_in, ser_valid, sync_in, par_ready,
    input  par_out, par_valid, locked, overflow, sync_err
  );

  modport slave (
    input  ser_in, ser_valid, sync_in, par_ready,
    output par_out, par_valid, locked, overflow, sync_err
  );
endinterface

// File: rtl/sipo_out_reg.sv
// Single-entry holding register presenting assembled words on a valid/ready port.
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             par_ready,
  output logic [WIDTH-1:0] par_out,
  output logic             par_valid,
  output logic             load_ok
);

  // A held word frees its slot in the same cycle it is consumed.
  assign load_ok = !par_valid || par_ready;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      par_out   <= '0;
      par_valid <= 1'b0;
    end else if (load && load_ok) begin
      par_out   <= load_data;
      par_valid <= 1'b1;
    end else if (par_ready) begin
      par_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deserializer.sv
// Framed serial-to-parallel receiver: word alignment FSM, bit counter, shift
// register and sticky error flags feeding a single-entry output register.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                clk,
  input logic                reset,
  sipo_deserializer_if.slave bus
);

  localparam int CW = clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic             overflow_q;
  logic             sync_err_q;

  logic             accept;
  logic             start;
  logic             resync;
  logic             word_done;
  logic             load_ok;
  logic [CW-1:0]    eff_cnt;
  logic [WIDTH-1:0] base;
  logic [WIDTH-1:0] assembled;

  always_comb begin
    // NOTE: every signal is assigned on every path so no latch is inferred.
    accept    = bus.ser_valid && (state == LOCKED || bus.sync_in);
    resync    = accept && state == LOCKED && bus.sync_in && cnt != '0;
    // A new word starts from an empty shift register, so stale bits never leak in.
    start     = (state == HUNT) || bus.sync_in || cnt == '0;
    eff_cnt   = start ? '0 : cnt;
    base      = start ? '0 : shreg;
    assembled = MSB_FIRST ? {base[WIDTH-2:0], bus.ser_in}
                          : {bus.ser_in, base[WIDTH-1:1]};
    word_done = accept && (eff_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= HUNT;
      cnt        <= '0;
      shreg      <= '0;
      overflow_q <= 1'b0;
      sync_err_q <= 1'b0;
    end else if (accept) begin
      state <= LOCKED;
      shreg <= assembled;
      cnt   <= word_done ? '0 : eff_cnt + CW'(1);
      if (resync) sync_err_q <= 1'b1;
      if (word_done && !load_ok) overflow_q <= 1'b1;
    end
  end

  sipo_out_reg #(.WIDTH(WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (word_done),
    .load_data (assembled),
    .par_ready (bus.par_ready),
    .par_out   (bus.par_out),
    .par_valid (bus.par_valid),
    .load_ok   (load_ok)
  );

  assign bus.locked   = (state == LOCKED);
  assign bus.overflow = overflow_q;
  assign bus.sync_err = sync_err_q;

endmodule
